// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add 32x32 multiplier (low 32 product bits) that drives
// an external ALU for every accumulate step and captures its sum and overflow.
module alu_mul_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_f,
  input  logic [31:0] alu_y,
  input  logic        alu_zero,
  input  logic        alu_of,
  output logic        done,
  output logic [31:0] product,
  output logic        ovf,
  output logic        prod_zero
);

  localparam logic [2:0] ALU_ADD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] m_q, m_d;
  logic [31:0] q_q, q_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] product_q, product_d;
  logic        ovf_q, ovf_d;
  logic        prod_zero_q, prod_zero_d;
  logic        done_q, done_d;
  logic        run_exit;

  // The zero flag of the external ALU carries no information we need.
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    m_d         = m_q;
    q_d         = q_q;
    count_d     = count_q;
    product_d   = product_q;
    ovf_d       = ovf_q;
    prod_zero_d = prod_zero_q;
    done_d      = 1'b0;
    run_exit    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d     = a_in;
          q_d     = b_in;
          acc_d   = 32'd0;
          ovf_d   = 1'b0;
          count_d = 5'd0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // The ALU is wired to acc_q + m_q, so its result is the accumulated sum.
        if (q_q[0]) begin
          acc_d = alu_y;
          ovf_d = ovf_q | alu_of;
        end
        m_d     = m_q << 1;
        q_d     = q_q >> 1;
        count_d = count_q + 5'd1;
        // Stop once no multiplier bits remain, or after the 32nd step.
        run_exit = (q_q[31:1] == 31'd0) || (count_q == 5'd31);
        if (run_exit) begin
          product_d   = acc_d;
          prod_zero_d = (acc_d == 32'd0);
          done_d      = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= 32'd0;
      m_q         <= 32'd0;
      q_q         <= 32'd0;
      count_q     <= 5'd0;
      product_q   <= 32'd0;
      ovf_q       <= 1'b0;
      prod_zero_q <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      m_q         <= m_d;
      q_q         <= q_d;
      count_q     <= count_d;
      product_q   <= product_d;
      ovf_q       <= ovf_d;
      prod_zero_q <= prod_zero_d;
      done_q      <= done_d;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign alu_a     = acc_q;
  assign alu_b     = m_q;
  assign alu_f     = ALU_ADD;
  assign done      = done_q;
  assign product   = product_q;
  assign ovf       = ovf_q;
  assign prod_zero = prod_zero_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioral adder standing in for the ALU.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_f;
  logic [31:0] alu_y;
  logic        alu_zero;
  logic        alu_of;
  logic        done;
  logic [31:0] product;
  logic        ovf;
  logic        prod_zero;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  // Behavioral ALU: add when f=010, signed overflow on like-signed operands.
  always_comb begin
    alu_y    = (alu_f == 3'b010) ? (alu_a + alu_b) : 32'd0;
    alu_of   = (alu_a[31] == alu_b[31]) && (alu_y[31] != alu_a[31]);
    alu_zero = (alu_y == 32'd0);
  end

  alu_mul_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .ready     (ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_f     (alu_f),
    .alu_y     (alu_y),
    .alu_zero  (alu_zero),
    .alu_of    (alu_of),
    .done      (done),
    .product   (product),
    .ovf       (ovf),
    .prod_zero (prod_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int exp_cyc,
                        input logic [31:0] exp_prod, input logic exp_ovf, input logic exp_pz,
                        input bit poke_run, input bit poke_done);
    int n;
    bit seen;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    check("ready_in_run", ready, 1'b0);
    check("ovf_clear_at_accept", ovf, 1'b0);
    seen = 1'b0;
    while (!seen && n < 100) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (poke_run && n == 5) start = 1'b1;
        @(posedge clk); #1;
        if (poke_run && n == 5) begin
          start = 1'b0;
          check("ready_after_midrun_start", ready, 1'b0);
        end
        n++;
      end
    end
    check("done_seen", seen, 1'b1);
    check("done_latency", n, exp_cyc);
    check("product", product, exp_prod);
    check("ovf", ovf, exp_ovf);
    check("prod_zero", prod_zero, exp_pz);
    if (poke_done) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_one_cycle", done, 1'b0);
    check("ready_after_done", ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("ready_idle_hold", ready, 1'b1);
    check("product_hold", product, exp_prod);
    check("ovf_hold", ovf, exp_ovf);
    check("prod_zero_hold", prod_zero, exp_pz);
    $display("op a=%h b=%h product=%h ovf=%0d prod_zero=%0d cycles=%0d",
             a, b, product, ovf, prod_zero, n);
  endtask

  initial begin
    bit seen_done;
    reset = 1'b1;
    start = 1'b0;
    a_in  = 32'd0;
    b_in  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_alu_f", alu_f, 3'b010);
    check("reset_ready", ready, 1'b1);
    check("reset_done", done, 1'b0);
    check("reset_product", product, 32'd0);
    check("reset_prod_zero", prod_zero, 1'b1);
    check("reset_ovf", ovf, 1'b0);
    check("reset_alu_a", alu_a, 32'd0);
    check("reset_alu_b", alu_b, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 3*5, with a start pulse during DONE that must be ignored
    run_op(32'd3, 32'd5, 4, 32'd15, 1'b0, 1'b0, 1'b0, 1'b1);
    // multiplier zero: single RUN cycle, no add
    run_op(32'h12345678, 32'd0, 2, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    // second add overflows in signed terms
    run_op(32'h30000000, 32'd3, 3, 32'h90000000, 1'b1, 1'b0, 1'b0, 1'b0);
    // full 32-step run with a start pulse in the middle
    run_op(32'd1, 32'hFFFFFFFF, 33, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0);

    // reset aborts an operation at RUN cycle 10
    a_in  = 32'd7;
    b_in  = 32'hFFFF0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("run1_alu_a", alu_a, 32'd0);
    check("run1_alu_b", alu_b, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_ready", ready, 1'b1);
    check("abort_done", done, 1'b0);
    check("abort_product", product, 32'd0);
    check("abort_prod_zero", prod_zero, 1'b1);
    check("abort_ovf", ovf, 1'b0);
    check("abort_alu_a", alu_a, 32'd0);
    check("abort_alu_b", alu_b, 32'd0);
    check("abort_alu_f", alu_f, 3'b010);
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    check("abort_no_done", seen_done, 1'b0);
    $display("op a=00000007 b=ffff0000 aborted by reset product=%h prod_zero=%0d", product, prod_zero);

    run_op(32'd6, 32'd7, 4, 32'd42, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 Parameters: none; width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 a_in  input  32  multiplicand, captured on accepted start.
REQ-006 b_in  input  32  multiplier, captured on accepted start.
REQ-007 ready  output  1  high in IDLE only.
REQ-008 alu_a  output  32  ALU A operand = accumulator register.
REQ-009 alu_b  output  32  ALU B operand = shifted-multiplicand register.
REQ-010 alu_f  output  3  ALU function select; constant 3'b010 (add).
REQ-011 alu_y  input  32  ALU result, combinational from alu_a/alu_b/alu_f in the same cycle.
REQ-012 alu_zero  input  1  ALU zero flag; unused, no functional effect.
REQ-013 alu_of  input  1  ALU signed-overflow flag for the current add.
REQ-014 done  output  1  one-cycle pulse when product is valid.
REQ-015 product  output  32  low 32 bits of unsigned a_in*b_in; held until next accepted start.
REQ-016 ovf  output  1  sticky: ALU reported alu_of=1 on any accumulate step of this operation.
REQ-017 prod_zero  output  1  high when product==0; registered, updated with product.

Function
REQ-018 Block SHALL act as an ALU initiator: drive an external 32-bit ALU each RUN cycle and capture alu_y/alu_of at the following edge.
REQ-019 FSM states: IDLE, RUN, DONE; reset state IDLE.
REQ-020 IDLE: if start=1, load M<=a_in, Q<=b_in, acc<=0, ovf<=0, count<=0, go RUN; else stay.
REQ-021 RUN, each cycle: if Q[0]=1 then acc<=alu_y and ovf<=ovf|alu_of; else acc unchanged; M<=M<<1 (zero fill, MSB discarded); Q<=Q>>1; count<=count+1.
REQ-022 RUN exits to DONE when (Q>>1)==0 or count==31; minimum one RUN cycle (b_in=0 gives one RUN cycle, no add).
REQ-023 RUN cycle count = max(1, index of MSB set in b_in + 1); max 32.
REQ-024 On RUN exit edge: product<=final acc value (including the add of that cycle), prod_zero<=(that value==0).
REQ-025 DONE: done=1 for exactly one cycle, then IDLE unconditionally; start in DONE ignored.
REQ-026 start while in RUN or DONE SHALL be ignored; no queuing.
REQ-027 Discarded high product bits SHALL not affect ovf; only alu_of does.
REQ-028 alu_a/alu_b SHALL reflect registers in all states; ALU outputs in IDLE/DONE are ignored.
REQ-029 product/ovf/prod_zero SHALL hold across IDLE until the next start accepted; ovf clears at accept.

Reset
REQ-030 reset=1 at an edge SHALL force IDLE and clear acc, M, Q, count, product, ovf to 0; prod_zero<=1; done<=0; ready=1 in the next cycle.
REQ-031 reset SHALL dominate start and any in-progress RUN; an aborted operation produces no done pulse.
REQ-032 alu_f SHALL read 3'b010 during and after reset.

Verification (bench uses a behavioral model of the team ALU)
REQ-033 a=3, b=5, start one cycle -> 3 RUN cycles, done pulse 4 cycles after start edge, product=15, ovf=0, prod_zero=0.
REQ-034 a=0x12345678, b=0 -> 1 RUN cycle, done 2 cycles after start, product=0, prod_zero=1, ovf=0.
REQ-035 a=0x30000000, b=3 -> second add 0x30000000+0x60000000 sets alu_of; product=0x90000000, ovf=1.
REQ-036 a=1, b=0xFFFFFFFF -> 32 RUN cycles, product=0xFFFFFFFF, ovf=0; start pulsed mid-RUN ignored (ready=0, result unchanged).
REQ-037 reset asserted at RUN cycle 10 of a=7,b=0xFFFF0000 -> IDLE next cycle, product=0, prod_zero=1, no done; next start a=6,b=7 -> product=42.
